// File: rtl/dcoffset_pkg.sv
// Shared definitions for the RX DC-offset load/track/hold sequencer.
package dcoffset_pkg;

   localparam int unsigned ADDR_W   = 7;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned LEN_W    = 16;
   localparam int unsigned NUM_CHAN = 4;
   localparam int unsigned CH_W     = 2;

   // Register offsets relative to CTRL_ADDR.
   localparam int unsigned REG_CTRL_OFS   = 0;
   localparam int unsigned REG_TIMING_OFS = 1;
   localparam int unsigned REG_SEED_OFS   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_TRACK = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } dco_wr_t;

endpackage

// File: rtl/strobe_down_counter.sv
// Down counter for state lengths: loads on state entry, counts sample strobes to zero.
module strobe_down_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         strobe,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= value;
      end else if (strobe && (cnt_q != '0)) begin
         cnt_q <= cnt_q - W'(1);
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/rx_dcoffset_seq.sv
// DC-offset sequencer: seeds the four offset channels, then alternates integrator
// tracking and holding on sample strobes, while forwarding host channel writes.
module rx_dcoffset_seq
   import dcoffset_pkg::*;
#(
   parameter logic [ADDR_W-1:0] CTRL_ADDR = 7'd48,
   parameter logic [ADDR_W-1:0] CHAN_BASE = 7'd10
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                sample_strobe,
   input  logic [ADDR_W-1:0]   serial_addr,
   input  logic [DATA_W-1:0]   serial_data,
   input  logic                serial_strobe,
   output logic [ADDR_W-1:0]   dco_addr,
   output logic [DATA_W-1:0]   dco_data,
   output logic                dco_strobe,
   output logic [NUM_CHAN-1:0] dco_enable,
   output logic                busy
);

   logic             ctrl_wr_c, timing_wr_c, seed_wr_c, fwd_c;
   logic             run_q, reload_q;
   logic [LEN_W-1:0] track_len_q, hold_len_q, seed_q;

   state_e              state_q, state_d;
   logic [CH_W-1:0]     ch_q, ch_d;
   logic                track_inf_q, track_inf_d;
   dco_wr_t             dco_q, dco_d;
   logic                dco_strobe_q, dco_strobe_d;
   logic [NUM_CHAN-1:0] dco_enable_q, dco_enable_d;
   logic                busy_q, busy_d;

   logic             enter_track_c, enter_hold_c;
   logic             cnt_load_c, cnt_zero_c;
   logic [LEN_W-1:0] cnt_value_c;

   assign ctrl_wr_c   = serial_strobe && (serial_addr == CTRL_ADDR + ADDR_W'(REG_CTRL_OFS));
   assign timing_wr_c = serial_strobe && (serial_addr == CTRL_ADDR + ADDR_W'(REG_TIMING_OFS));
   assign seed_wr_c   = serial_strobe && (serial_addr == CTRL_ADDR + ADDR_W'(REG_SEED_OFS));
   assign fwd_c       = serial_strobe &&
                        (ADDR_W'(serial_addr - CHAN_BASE) < ADDR_W'(NUM_CHAN));

   // Host-visible configuration registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         run_q       <= 1'b0;
         reload_q    <= 1'b0;
         track_len_q <= '0;
         hold_len_q  <= '0;
         seed_q      <= '0;
      end else begin
         if (ctrl_wr_c) begin
            run_q    <= serial_data[0];
            reload_q <= serial_data[1];
         end
         if (timing_wr_c) begin
            track_len_q <= serial_data[LEN_W-1:0];
            hold_len_q  <= serial_data[DATA_W-1:LEN_W];
         end
         if (seed_wr_c) begin
            seed_q <= serial_data[LEN_W-1:0];
         end
      end
   end

   strobe_down_counter #(.W(LEN_W)) u_len_cnt (
      .clock  (clock),
      .reset  (reset),
      .load   (cnt_load_c),
      .value  (cnt_value_c),
      .strobe (sample_strobe),
      .zero   (cnt_zero_c)
   );

   // Next state; a host channel write always owns the dco bus and stalls LOAD.
   always_comb begin
      state_d       = state_q;
      ch_d          = ch_q;
      track_inf_d   = track_inf_q;
      dco_d         = dco_q;
      dco_strobe_d  = 1'b0;
      enter_track_c = 1'b0;
      enter_hold_c  = 1'b0;
      cnt_load_c    = 1'b0;
      cnt_value_c   = track_len_q;

      if (fwd_c) begin
         dco_d.addr   = serial_addr;
         dco_d.data   = serial_data;
         dco_strobe_d = 1'b1;
      end

      if (ctrl_wr_c && !serial_data[0]) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (run_q) begin
                  if (reload_q) begin
                     state_d = ST_LOAD;
                     ch_d    = '0;
                  end else begin
                     enter_track_c = 1'b1;
                  end
               end
            end
            ST_LOAD: begin
               if (!fwd_c) begin
                  dco_d.addr   = CHAN_BASE + ADDR_W'(ch_q);
                  dco_d.data   = {16'b0, seed_q};
                  dco_strobe_d = 1'b1;
                  if (ch_q == CH_W'(NUM_CHAN - 1)) begin
                     enter_track_c = 1'b1;
                  end else begin
                     ch_d = ch_q + CH_W'(1);
                  end
               end
            end
            ST_TRACK: begin
               if (!track_inf_q && cnt_zero_c) begin
                  if (hold_len_q != '0) begin
                     enter_hold_c = 1'b1;
                  end else begin
                     enter_track_c = 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (cnt_zero_c) begin
                  enter_track_c = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Lengths are sampled only here, so timing writes never disturb a running count.
      if (enter_track_c) begin
         state_d     = ST_TRACK;
         cnt_load_c  = 1'b1;
         cnt_value_c = track_len_q;
         track_inf_d = (track_len_q == '0);
      end else if (enter_hold_c) begin
         state_d     = ST_HOLD;
         cnt_load_c  = 1'b1;
         cnt_value_c = hold_len_q;
      end

      dco_enable_d = (state_d == ST_TRACK) ? {NUM_CHAN{1'b1}} : '0;
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ch_q         <= '0;
         track_inf_q  <= 1'b0;
         dco_q        <= '0;
         dco_strobe_q <= 1'b0;
         dco_enable_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ch_q         <= ch_d;
         track_inf_q  <= track_inf_d;
         dco_q        <= dco_d;
         dco_strobe_q <= dco_strobe_d;
         dco_enable_q <= dco_enable_d;
         busy_q       <= busy_d;
      end
   end

   assign dco_addr   = dco_q.addr;
   assign dco_data   = dco_q.data;
   assign dco_strobe = dco_strobe_q;
   assign dco_enable = dco_enable_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_rx_dcoffset_seq.sv
// Self-checking bench for rx_dcoffset_seq: per-cycle behavioural model plus
// hand-computed scenario expectations.
module tb_rx_dcoffset_seq;

   localparam logic [6:0] CTRL = 7'd48;
   localparam logic [6:0] CHB  = 7'd10;
   localparam logic [1:0] M_IDLE = 2'd0, M_LOAD = 2'd1, M_TRACK = 2'd2, M_HOLD = 2'd3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        sample_strobe = 1'b0;
   logic [6:0]  serial_addr = '0;
   logic [31:0] serial_data = '0;
   logic        serial_strobe = 1'b0;
   logic [6:0]  dco_addr;
   logic [31:0] dco_data;
   logic        dco_strobe;
   logic [3:0]  dco_enable;
   logic        busy;

   int n_pass = 0;
   int n_total = 0;
   bit strobe_on = 1'b0;
   int phase = 0;

   rx_dcoffset_seq #(.CTRL_ADDR(CTRL), .CHAN_BASE(CHB)) dut (
      .clock         (clock),
      .reset         (reset),
      .sample_strobe (sample_strobe),
      .serial_addr   (serial_addr),
      .serial_data   (serial_data),
      .serial_strobe (serial_strobe),
      .dco_addr      (dco_addr),
      .dco_data      (dco_data),
      .dco_strobe    (dco_strobe),
      .dco_enable    (dco_enable),
      .busy          (busy)
   );

   always #5 clock = ~clock;

   // ADC sample pulse every fourth cycle.
   always @(posedge clock) begin
      #1;
      phase = (phase + 1) % 4;
      sample_strobe = strobe_on && (phase == 0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
   endtask

   // Behavioural model: mode, strobes seen in the current phase, next channel to seed.
   typedef struct packed {
      logic [1:0]  mode;
      logic        run;
      logic        reload;
      logic [15:0] track;
      logic [15:0] hold;
      logic [15:0] seed;
      logic [2:0]  next_ch;
      logic [31:0] seen;
      logic [15:0] len;
      logic        inf;
      logic        stb;
      logic [6:0]  addr;
      logic [31:0] data;
      logic [3:0]  en;
      logic        busy;
   } m_t;

   m_t m = '0;

   function automatic m_t model_next(input m_t c, input logic ss, input logic [6:0] a,
                                     input logic [31:0] d, input logic smp);
      m_t  n = c;
      bit  ctrl = ss && (a == CTRL);
      bit  tim  = ss && (a == CTRL + 7'd1);
      bit  sd   = ss && (a == CTRL + 7'd2);
      bit  fwd  = ss && (int'(a) >= int'(CHB)) && (int'(a) <= int'(CHB) + 3);
      bit  to_track = 1'b0;
      n.stb = 1'b0;
      if (fwd) begin
         n.stb = 1'b1; n.addr = a; n.data = d;
      end
      if (ctrl && !d[0]) begin
         n.mode = M_IDLE;
      end else begin
         case (c.mode)
            M_IDLE: if (c.run) begin
               if (c.reload) begin n.mode = M_LOAD; n.next_ch = 3'd0; end
               else to_track = 1'b1;
            end
            M_LOAD: if (!fwd) begin
               n.stb = 1'b1;
               n.addr = CHB + 7'(c.next_ch);
               n.data = {16'h0000, c.seed};
               n.next_ch = c.next_ch + 3'd1;
               if (c.next_ch == 3'd3) to_track = 1'b1;
            end
            M_TRACK: begin
               if (!c.inf && c.seen == 32'(c.len)) begin
                  if (c.hold != 16'd0) begin
                     n.mode = M_HOLD; n.len = c.hold; n.seen = 0;
                  end else to_track = 1'b1;
               end else if (smp) n.seen = c.seen + 1;
            end
            default: begin
               if (c.seen == 32'(c.len)) to_track = 1'b1;
               else if (smp) n.seen = c.seen + 1;
            end
         endcase
      end
      if (to_track) begin
         n.mode = M_TRACK; n.len = c.track; n.inf = (c.track == 16'd0); n.seen = 0;
      end
      n.en   = (n.mode == M_TRACK) ? 4'hF : 4'h0;
      n.busy = (n.mode != M_IDLE);
      if (ctrl) begin n.run = d[0]; n.reload = d[1]; end
      if (tim)  begin n.track = d[15:0]; n.hold = d[31:16]; end
      if (sd)   n.seed = d[15:0];
      return n;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) m <= '0;
      else m <= model_next(m, serial_strobe, serial_addr, serial_data, sample_strobe);
   end

   always @(negedge clock) begin
      if (!reset) begin
         check("dco_strobe", 32'(dco_strobe), 32'(m.stb));
         check("dco_addr",   32'(dco_addr),   32'(m.addr));
         check("dco_data",   dco_data,        m.data);
         check("dco_enable", 32'(dco_enable), 32'(m.en));
         check("busy",       32'(busy),       32'(m.busy));
      end
   end

   // Logs of dco writes and of enable runs (level, sample strobes during the run).
   logic [6:0]  st_addr[$];
   logic [31:0] st_data[$];
   logic [3:0]  run_lvl[$];
   int          run_cnt[$];
   logic [3:0]  cur_lvl = 4'h0;
   int          cur_cnt = 0;

   always @(negedge clock) begin
      if (reset) begin
         cur_lvl <= 4'h0;
         cur_cnt <= 0;
      end else if (dco_enable != cur_lvl) begin
         run_lvl.push_back(cur_lvl);
         run_cnt.push_back(cur_cnt);
         cur_lvl <= dco_enable;
         cur_cnt <= int'(sample_strobe);
      end else begin
         cur_cnt <= cur_cnt + int'(sample_strobe);
      end
      if (!reset && dco_strobe) begin
         st_addr.push_back(dco_addr);
         st_data.push_back(dco_data);
      end
   end

   task automatic host_wr(input logic [6:0] a, input logic [31:0] d);
      @(posedge clock); #1;
      serial_addr = a; serial_data = d; serial_strobe = 1'b1;
      @(posedge clock); #1;
      serial_strobe = 1'b0;
   endtask

   task automatic wait_en(input string name, input logic [3:0] lvl);
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (dco_enable == lvl) break;
      end
      check(name, 32'(dco_enable), 32'(lvl));
   endtask

   task automatic check_run(input string name, input int idx, input logic [3:0] lvl, input int cnt);
      check({name, "_exists"}, 32'(run_lvl.size() > idx), 32'd1);
      if (run_lvl.size() > idx) begin
         check({name, "_level"}, 32'(run_lvl[idx]), 32'(lvl));
         check({name, "_strobes"}, 32'(run_cnt[idx]), 32'(cnt));
      end
   endtask

   task automatic check_wr(input string name, input int idx, input logic [6:0] a, input logic [31:0] d);
      if (st_addr.size() > idx) begin
         check({name, "_addr"}, 32'(st_addr[idx]), 32'(a));
         check({name, "_data"}, st_data[idx], d);
      end else begin
         check({name, "_exists"}, 32'(st_addr.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      int sb;
      int ri;
      int fi;
      bit found;

      #1 reset = 1'b1;
      #1;
      check("rst_addr", 32'(dco_addr), 32'd0);
      check("rst_data", dco_data, 32'd0);
      check("rst_strobe", 32'(dco_strobe), 32'd0);
      check("rst_enable", 32'(dco_enable), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      strobe_on = 1'b1;

      // Seed, timing {hold 2, track 3}, start with reload.
      host_wr(CTRL + 7'd2, 32'h0000_0123);
      host_wr(CTRL + 7'd1, {16'd2, 16'd3});
      sb = st_addr.size();
      ri = run_lvl.size();
      host_wr(CTRL, 32'd3);
      repeat (110) @(posedge clock);
      check("s1_nwrites", 32'(st_addr.size() - sb), 32'd4);
      for (int k = 0; k < 4; k++) check_wr("s1_wr", sb + k, CHB + 7'(k), 32'h0000_0123);
      found = 1'b0;
      fi = 0;
      for (int i = ri; i < run_lvl.size(); i++) begin
         if (!found && run_lvl[i] == 4'hF) begin found = 1'b1; fi = i; end
      end
      check("s1_track_found", 32'(found), 32'd1);
      check_run("s1_run0", fi, 4'hF, 3);
      check_run("s1_run1", fi + 1, 4'h0, 2);
      check_run("s1_run2", fi + 2, 4'hF, 3);
      check_run("s1_run3", fi + 3, 4'h0, 2);

      // Timing rewrite mid-TRACK: current TRACK keeps 3, HOLD becomes 4, then TRACK 1.
      wait_en("s5_wait_hold", 4'h0);
      wait_en("s5_wait_track", 4'hF);
      repeat (2) @(posedge clock);
      ri = run_lvl.size();
      host_wr(CTRL + 7'd1, {16'd4, 16'd1});
      repeat (80) @(posedge clock);
      check_run("s5_cur_track", ri, 4'hF, 3);
      check_run("s5_new_hold", ri + 1, 4'h0, 4);
      check_run("s5_new_track", ri + 2, 4'hF, 1);

      // Start while busy must not restart the sequence.
      sb = st_addr.size();
      host_wr(CTRL, 32'd3);
      repeat (20) @(posedge clock);
      check("s5_no_restart", 32'(st_addr.size() - sb), 32'd0);
      check("s5_still_busy", 32'(busy), 32'd1);
      host_wr(CTRL, 32'd0);
      check("s5_stop_enable", 32'(dco_enable), 32'd0);
      check("s5_stop_busy", 32'(busy), 32'd0);

      // Host write to channel 1 collides with LOAD's channel-1 write.
      sb = st_addr.size();
      host_wr(CTRL, 32'd3);
      @(posedge clock);
      host_wr(7'd11, 32'hABCD_0011);
      repeat (20) @(posedge clock);
      check("s2_nwrites", 32'(st_addr.size() - sb), 32'd5);
      check_wr("s2_wr0", sb,     7'd10, 32'h0000_0123);
      check_wr("s2_wr1", sb + 1, 7'd11, 32'hABCD_0011);
      check_wr("s2_wr2", sb + 2, 7'd11, 32'h0000_0123);
      check_wr("s2_wr3", sb + 3, 7'd12, 32'h0000_0123);
      check_wr("s2_wr4", sb + 4, 7'd13, 32'h0000_0123);
      host_wr(CTRL, 32'd0);

      // track_len=0: continuous TRACK until stopped.
      host_wr(CTRL + 7'd1, {16'd2, 16'd0});
      host_wr(CTRL, 32'd1);
      wait_en("s3_wait_track", 4'hF);
      repeat (2) @(posedge clock);
      ri = run_lvl.size();
      repeat (100) @(posedge clock);
      check("s3_no_exit", 32'(run_lvl.size() - ri), 32'd0);
      check("s3_busy", 32'(busy), 32'd1);
      host_wr(CTRL, 32'd0);
      check("s3_stop_enable", 32'(dco_enable), 32'd0);
      check("s3_stop_busy", 32'(busy), 32'd0);

      // hold_len=0, track_len=1: enable never drops across re-entries.
      host_wr(CTRL + 7'd1, {16'd0, 16'd1});
      host_wr(CTRL, 32'd1);
      wait_en("s4_wait_track", 4'hF);
      repeat (2) @(posedge clock);
      ri = run_lvl.size();
      repeat (60) @(posedge clock);
      check("s4_no_gap", 32'(run_lvl.size() - ri), 32'd0);
      check("s4_enable", 32'(dco_enable), 32'hF);
      host_wr(CTRL, 32'd0);

      // Reset after the second LOAD write.
      host_wr(CTRL + 7'd1, {16'd2, 16'd3});
      sb = st_addr.size();
      host_wr(CTRL, 32'd3);
      for (int i = 0; i < 30; i++) begin
         @(negedge clock); #1;
         if (st_addr.size() >= sb + 2) break;
      end
      check("s6_two_writes", 32'(st_addr.size() - sb), 32'd2);
      #1 reset = 1'b1;
      #1;
      check("s6_rst_addr", 32'(dco_addr), 32'd0);
      check("s6_rst_data", dco_data, 32'd0);
      check("s6_rst_strobe", 32'(dco_strobe), 32'd0);
      check("s6_rst_enable", 32'(dco_enable), 32'd0);
      check("s6_rst_busy", 32'(busy), 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      repeat (20) @(posedge clock);
      check("s6_no_more_writes", 32'(st_addr.size() - sb), 32'd2);
      check("s6_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
